// File: rtl/operand_forward_unit.sv
// Operand forwarding/bypass for the even and odd execution pipes: picks the youngest in-flight
// result per source register, stalls on unready producers, registers operands. Optional FWD_STATS_EN.
module operand_forward_unit #(
  parameter int NUM_STAGES  = 7,
  parameter int PACK_W      = 143,
  parameter int STALL_LIMIT = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         dec_valid,
  input  logic [6:0]                   ra_addr,
  input  logic [6:0]                   rb_addr,
  input  logic [6:0]                   rc_addr,
  input  logic [2:0]                   src_used,
  input  logic [127:0]                 rf_ra_data,
  input  logic [127:0]                 rf_rb_data,
  input  logic [127:0]                 rf_rc_data,
  input  logic [NUM_STAGES*PACK_W-1:0] even_stages,
  input  logic [NUM_STAGES*PACK_W-1:0] odd_stages,
  input  logic [6:0]                   even_wb_addr,
  input  logic [6:0]                   odd_wb_addr,
  input  logic [127:0]                 even_wb_data,
  input  logic [127:0]                 odd_wb_data,
  input  logic                         even_wb_en,
  input  logic                         odd_wb_en,
  output logic                         stall,
  output logic                         op_valid,
  output logic [127:0]                 op_ra_data,
  output logic [127:0]                 op_rb_data,
  output logic [127:0]                 op_rc_data,
  output logic                         hazard_err
`ifdef FWD_STATS_EN
  ,
  output logic [31:0]                  stall_cycles,
  output logic [31:0]                  fwd_hits
`endif
);

  localparam int DATA_W  = 128;
  localparam int RES_LSB = 3;
  localparam int DST_LSB = 131;
  localparam int LAT_LSB = 138;
  localparam int WR_BIT  = 142;
  localparam int CNT_W   = $clog2(STALL_LIMIT + 1);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              fwd;
    logic              hazard;
  } res_t;

  // Youngest match wins; a younger unready match blocks any older ready one.
  function automatic res_t resolve(
    input logic [6:0]                   addr,
    input logic [NUM_STAGES*PACK_W-1:0] ev,
    input logic [NUM_STAGES*PACK_W-1:0] od,
    input logic                         ewe,
    input logic [6:0]                   ewa,
    input logic [DATA_W-1:0]            ewd,
    input logic                         owe,
    input logic [6:0]                   owa,
    input logic [DATA_W-1:0]            owd,
    input logic [DATA_W-1:0]            rf
  );
    res_t              r;
    logic              found;
    logic [PACK_W-1:0] e;
    logic [3:0]        lat;
    r.data   = rf;
    r.fwd    = 1'b0;
    r.hazard = 1'b0;
    found    = 1'b0;
    for (int k = 1; k <= NUM_STAGES; k++) begin
      for (int p = 0; p < 2; p++) begin
        e   = (p == 0) ? ev[(k-1)*PACK_W +: PACK_W] : od[(k-1)*PACK_W +: PACK_W];
        lat = e[LAT_LSB +: 4];
        if (!found && e[WR_BIT] && (e[DST_LSB +: 7] == addr)) begin
          found    = 1'b1;
          r.data   = e[RES_LSB +: DATA_W];
          r.fwd    = 1'b1;
          r.hazard = (k < int'({28'd0, lat}));
        end
      end
    end
    if (!found && ewe && (ewa == addr)) begin
      r.data = ewd;
      r.fwd  = 1'b1;
    end else if (!found && owe && (owa == addr)) begin
      r.data = owd;
      r.fwd  = 1'b1;
    end
    return r;
  endfunction

  res_t             w_ra_p0, w_rb_p0, w_rc_p0;
  logic [2:0]       w_hz_p0;
  logic [2:0]       w_fwd_p0;
  logic             w_issue_p0;

  always_comb begin
    w_ra_p0 = resolve(ra_addr, even_stages, odd_stages, even_wb_en, even_wb_addr, even_wb_data,
                      odd_wb_en, odd_wb_addr, odd_wb_data, rf_ra_data);
    w_rb_p0 = resolve(rb_addr, even_stages, odd_stages, even_wb_en, even_wb_addr, even_wb_data,
                      odd_wb_en, odd_wb_addr, odd_wb_data, rf_rb_data);
    w_rc_p0 = resolve(rc_addr, even_stages, odd_stages, even_wb_en, even_wb_addr, even_wb_data,
                      odd_wb_en, odd_wb_addr, odd_wb_data, rf_rc_data);
    w_hz_p0  = {w_rc_p0.hazard, w_rb_p0.hazard, w_ra_p0.hazard} & src_used;
    w_fwd_p0 = {w_rc_p0.fwd, w_rb_p0.fwd, w_ra_p0.fwd} & src_used;
  end

  assign stall      = dec_valid & (|w_hz_p0);
  assign w_issue_p0 = dec_valid & ~stall;

  // p0 -> p1: resolved operands registered for execute
  logic              r_vld_p1;
  logic [DATA_W-1:0] r_ra_p1, r_rb_p1, r_rc_p1;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic              r_hazard_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1     <= 1'b0;
      r_ra_p1      <= '0;
      r_rb_p1      <= '0;
      r_rc_p1      <= '0;
      r_stall_cnt  <= '0;
      r_hazard_err <= 1'b0;
    end else begin
      r_vld_p1 <= w_issue_p0;
      if (w_issue_p0) begin
        r_ra_p1 <= w_ra_p0.data;
        r_rb_p1 <= w_rb_p0.data;
        r_rc_p1 <= w_rc_p0.data;
      end
      if (stall) begin
        if (r_stall_cnt != CNT_W'(STALL_LIMIT))
          r_stall_cnt <= r_stall_cnt + 1'b1;
        if (r_stall_cnt >= CNT_W'(STALL_LIMIT - 1))
          r_hazard_err <= 1'b1;
      end else begin
        r_stall_cnt <= '0;
      end
    end
  end

  assign op_valid   = r_vld_p1;
  assign op_ra_data = r_ra_p1;
  assign op_rb_data = r_rb_p1;
  assign op_rc_data = r_rc_p1;
  assign hazard_err = r_hazard_err;

`ifdef FWD_STATS_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_fwd_hits;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_fwd_hits     <= '0;
    end else begin
      if (stall)
        r_stall_cycles <= r_stall_cycles + 32'd1;
      if (w_issue_p0)
        r_fwd_hits <= r_fwd_hits + {31'd0, w_fwd_p0[0]} + {31'd0, w_fwd_p0[1]} + {31'd0, w_fwd_p0[2]};
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign fwd_hits     = r_fwd_hits;
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^w_fwd_p0;
`endif

endmodule

// File: doc/operand_forward_unit.md
Name: operand_forward_unit

Overview:
- Consumer end of the packed stage-result bus driven by the even and odd execution pipes; sits between the register-file read stage and both pipes' operand inputs.
- Per operand (ra, rb, rc), selects the youngest in-flight result for that register: pipe stages 1..7, then write-back (WB), then register file.
- Stalls issue while the producing result is still in flight but not yet ready.
- Registers the resolved operands for the execute stage.

Parameters:
- NUM_STAGES, 7, number of packed stages per pipe.
- PACK_W, 143, packed entry width: [0:2] unit_id, [3:130] result, [131:137] reg_dst, [138:141] latency, [142] reg_wr.
- STALL_LIMIT, 8, consecutive stall cycles before hazard_err is raised.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- dec_valid  in  1  decoded instruction presented this cycle.
- ra_addr, rb_addr, rc_addr  in  7 each  source register addresses.
- src_used  in  3  [0]=ra, [1]=rb, [2]=rc; operand is read.
- rf_ra_data, rf_rb_data, rf_rc_data  in  128 each  register-file read data.
- even_stages  in  NUM_STAGES*PACK_W  stage k at bits [(k-1)*PACK_W : k*PACK_W-1].
- odd_stages  in  NUM_STAGES*PACK_W  same layout as even_stages.
- even_wb_addr, odd_wb_addr  in  7  write-back addresses.
- even_wb_data, odd_wb_data  in  128  write-back data.
- even_wb_en, odd_wb_en  in  1  write-back enables.
- stall  out  1  combinational; hold decode.
- op_valid  out  1  registered operands valid.
- op_ra_data, op_rb_data, op_rc_data  out  128 each  registered resolved operands.
- hazard_err  out  1  sticky stall-timeout flag.

Behaviour:
- Reset: op_valid=0; op_*_data=0; hazard_err=0; stall counter=0. Statistics counters=0 when the optional feature is compiled in.
- Stage entry match: reg_wr=1 and reg_dst equals the source address.
- Ready rule: an entry at stage k is ready if k >= latency. Latency 0 is always ready.
- Search order per operand:
  - even stage 1, odd stage 1, even stage 2, ..., odd stage 7, even WB, odd WB, register file.
  - The first match wins. Even wins over odd at the same depth.
- Hazard: an operand with src_used=1 whose first match is not ready raises hazard. Older ready matches do not override a younger unready match.
- stall = dec_valid and (any operand hazard). Unused operands never stall.
- Posedge, dec_valid=1 and stall=0: op_valid<=1; op_*_data<=resolved values. Unused operands still load their resolved value.
- Posedge, stall=1 or dec_valid=0: op_valid<=0; op_*_data hold.
- Stall counter:
  - Increments on every stalled cycle, saturating at STALL_LIMIT.
  - Clears on any non-stalled cycle.
  - Reaching STALL_LIMIT sets hazard_err, which stays set until rst.
- Operand latency: issue cycle t, op_* valid after posedge t+1.
- rst asserted mid-stall clears everything immediately. No partial operand is retained.
- Simultaneous match in stage 7 and WB: stage 7 wins as the younger entry.

Optional Feature:
- FWD_STATS_EN defined: adds output ports stall_cycles (32) and fwd_hits (32).
  - stall_cycles increments per stall cycle.
  - fwd_hits increments per accepted issue for each used operand taken from a stage or WB rather than the register file (+0..3 per issue).
  - Both counters wrap at 2^32 and reset to 0.
- FWD_STATS_EN undefined: neither port nor counter exists. All other behaviour is identical.

Test Plan:
- No matches; rf_ra_data=0xA5.., src_used=3'b001, dec_valid=1 -> stall=0; next cycle op_valid=1, op_ra_data=0xA5...
- Odd stage 3 entry {reg_dst=5, latency=2, reg_wr=1, result=0x11..}; ra_addr=5 -> op_ra_data=0x11.., no stall.
- Odd stage 1 entry {reg_dst=9, latency=6}; rb_addr=9, src_used[1]=1:
  - stall=1 for 5 cycles while the entry advances through stages 1..5.
  - At stage 6, stall=0; op_rb_data equals the entry result.
- Even stage 2 and odd stage 2 both target reg 4 (0xEE.. vs 0x00..) -> op_rc_data=0xEE...
- Stage 7 {reg 3, 0x77..} and even_wb {reg 3, 0x33..} -> 0x77..; remove stage 7 -> 0x33...
- Unready match held for 8 cycles -> hazard_err=1 and stays 1 after the match clears; rst -> hazard_err=0, op_valid=0.
